fp_divide_iterative: RTL and testbench

Single-precision IEEE-754 divider (out = in1 / in2) built as the iterative counterpart to the pipelined multiplier in the FP ALU. It uses the same input-flag classification, flush-to-zero policy, rounding modes and exception flags as the multiplier. It produces one quotient bit per cycle with a restoring divider under a small FSM and a ready/valid handshake. It handles one operation at a time.

---
 rtl/fp_pkg.sv | 37 +++
 rtl/floating_point_rounder.sv | 36 +++
 rtl/fp_divide_iterative.sv | 243 ++++++++++++++++++++++++
 tb/tb_fp_divide_iterative.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared single-precision FP types and constants for the FP ALU.
// Provides fp_32b_t, rounding modes, canonical constants and FSM states.
package fp_pkg;

   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [22:0] mant;
   } fp_32b_t;

   typedef struct packed {
      logic overflow;
      logic underflow;
      logic inexact;
      logic invalid;
      logic div_zero;
   } fp_flags_t;

   localparam logic [2:0] RM_RNE = 3'b000;
   localparam logic [2:0] RM_RTZ = 3'b001;
   localparam logic [2:0] RM_RDN = 3'b010;
   localparam logic [2:0] RM_RUP = 3'b011;
   localparam logic [2:0] RM_RMM = 3'b100;

   localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;
   localparam logic [31:0] FP_INF  = 32'h7F80_0000;
   localparam logic [31:0] FP_MAX  = 32'h7F7F_FFFF;

   localparam logic [4:0] DIV_LAST = 5'd25;

   typedef enum logic [1:0] {
      IDLE,
      DIVIDE,
      ROUND
   } div_state_t;

endpackage

// File: rtl/floating_point_rounder.sv
// Rounds a 23-bit mantissa using guard/round/sticky and the rounding mode.
// Ports: sign, rounding_mode, mant_in, guard, round, sticky in;
//        mant_out, carry_out (mantissa wrapped), inexact out.
module floating_point_rounder
   import fp_pkg::*;
(
   input  logic        sign,
   input  logic [2:0]  rounding_mode,
   input  logic [22:0] mant_in,
   input  logic        guard,
   input  logic        round,
   input  logic        sticky,
   output logic [22:0] mant_out,
   output logic        carry_out,
   output logic        inexact
);

   logic lost;
   logic round_up;

   always_comb begin
      lost     = guard | round | sticky;
      round_up = 1'b0;
      case (rounding_mode)
         RM_RTZ:  round_up = 1'b0;
         RM_RDN:  round_up = sign & lost;
         RM_RUP:  round_up = ~sign & lost;
         RM_RMM:  round_up = guard;
         default: round_up = guard & (round | sticky | mant_in[0]);
      endcase
      // carry_out with mant_out==0 means the significand reached 2.0
      {carry_out, mant_out} = {1'b0, mant_in} + {23'b0, round_up};
      inexact = lost;
   end

endmodule

// File: rtl/fp_divide_iterative.sv
// Iterative single-precision divider, one restoring quotient bit per cycle.
// Ports: clk, rst, valid_data_in/ready_out, in1/in2, rounding_mode in;
//        out, five exception flags and a valid_data_out pulse out.
module fp_divide_iterative
   import fp_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_data_in,
   output logic        ready_out,
   input  logic [31:0] in1,
   input  logic [31:0] in2,
   input  logic [2:0]  rounding_mode,
   output logic [31:0] out,
   output logic        overflow,
   output logic        underflow,
   output logic        inexact,
   output logic        invalid_operation,
   output logic        divide_by_zero,
   output logic        valid_data_out
);

   div_state_t         state_q, state_d;
   logic [25:0]        rem_q, rem_d;
   logic [24:0]        quo_q, quo_d;
   logic [23:0]        div_q, div_d;
   logic signed [9:0]  exp_q, exp_d;
   logic [4:0]         cnt_q, cnt_d;
   logic               sign_q, sign_d;
   logic [2:0]         mode_q, mode_d;
   logic               special_q, special_d;
   logic [31:0]        spec_res_q, spec_res_d;
   fp_flags_t          spec_flg_q, spec_flg_d;
   logic [31:0]        out_q, out_d;
   fp_flags_t          flg_q, flg_d;
   logic               vld_q, vld_d;

   fp_32b_t            x, y;
   logic               x_den, y_den, x_zero, y_zero;
   logic               x_inf, y_inf, x_nan, y_nan;
   logic               sgn, special;
   logic [31:0]        c_res;
   fp_flags_t          c_flg;
   logic [23:0]        a_sig, b_sig;
   logic [25:0]        rem_init;
   logic signed [9:0]  exp_init;

   logic               rem_ge;
   logic [25:0]        rem_sub;

   logic [22:0]        rnd_mant;
   logic               rnd_carry, rnd_inexact;
   logic signed [9:0]  exp_r;
   logic [31:0]        n_res;
   fp_flags_t          n_flg;

   assign x = in1;
   assign y = in2;

   // Operand classification; denormals count as zero.
   always_comb begin
      x_zero  = x.exp == 8'd0;
      y_zero  = y.exp == 8'd0;
      x_den   = x_zero & (x.mant != 23'd0);
      y_den   = y_zero & (y.mant != 23'd0);
      x_inf   = (x.exp == 8'hFF) & (x.mant == 23'd0);
      y_inf   = (y.exp == 8'hFF) & (y.mant == 23'd0);
      x_nan   = (x.exp == 8'hFF) & (x.mant != 23'd0);
      y_nan   = (y.exp == 8'hFF) & (y.mant != 23'd0);
      sgn     = x.sign ^ y.sign;
      special = x_zero | y_zero | (x.exp == 8'hFF) | (y.exp == 8'hFF);

      c_flg           = '0;
      c_flg.underflow = x_den | y_den;
      if (x_nan & x.mant[22]) begin
         c_res = in1;
      end else if (y_nan & y.mant[22]) begin
         c_res = in2;
      end else if (x_nan) begin
         c_res         = in1 | 32'h0040_0000;
         c_flg.invalid = 1'b1;
      end else if (y_nan) begin
         c_res         = in2 | 32'h0040_0000;
         c_flg.invalid = 1'b1;
      end else if ((x_inf & y_inf) | (x_zero & y_zero)) begin
         c_res         = {sgn, FP_QNAN[30:0]};
         c_flg.invalid = 1'b1;
      end else if (x_inf) begin
         c_res = {sgn, FP_INF[30:0]};
      end else if (y_inf) begin
         c_res = {sgn, 31'd0};
      end else if (y_zero) begin
         c_res          = {sgn, FP_INF[30:0]};
         c_flg.div_zero = 1'b1;
      end else begin
         c_res = {sgn, 31'd0};
      end
   end

   // Pre-normalise the dividend so the quotient lands in [1,2).
   always_comb begin
      a_sig    = {1'b1, x.mant};
      b_sig    = {1'b1, y.mant};
      exp_init = $signed({2'b00, x.exp}) - $signed({2'b00, y.exp})
               + 10'sd127;
      if (a_sig < b_sig) begin
         rem_init = {1'b0, a_sig, 1'b0};
         exp_init = exp_init - 10'sd1;
      end else begin
         rem_init = {2'b00, a_sig};
      end
   end

   assign rem_ge  = rem_q >= {2'b00, div_q};
   assign rem_sub = rem_q - {2'b00, div_q};

   floating_point_rounder u_rnd (
      .sign          (sign_q),
      .rounding_mode (mode_q),
      .mant_in       (quo_q[24:2]),
      .guard         (quo_q[1]),
      .round         (quo_q[0]),
      .sticky        (|rem_q),
      .mant_out      (rnd_mant),
      .carry_out     (rnd_carry),
      .inexact       (rnd_inexact)
   );

   always_comb begin
      exp_r = exp_q + $signed({9'd0, rnd_carry});
      n_flg = '0;
      if (exp_r > 10'sd254) begin
         n_flg.overflow = 1'b1;
         n_flg.inexact  = 1'b1;
         case (mode_q)
            RM_RTZ:  n_res = {sign_q, FP_MAX[30:0]};
            RM_RDN:  n_res = sign_q ? {1'b1, FP_INF[30:0]} : FP_MAX;
            RM_RUP:  n_res = sign_q ? {1'b1, FP_MAX[30:0]} : FP_INF;
            default: n_res = {sign_q, FP_INF[30:0]};
         endcase
      end else if (exp_r <= 10'sd0) begin
         n_res           = {sign_q, 31'd0};
         n_flg.underflow = 1'b1;
         n_flg.inexact   = 1'b1;
      end else begin
         n_res         = {sign_q, exp_r[7:0], rnd_mant};
         n_flg.inexact = rnd_inexact;
      end
   end

   always_comb begin
      state_d    = state_q;
      rem_d      = rem_q;
      quo_d      = quo_q;
      div_d      = div_q;
      exp_d      = exp_q;
      cnt_d      = cnt_q;
      sign_d     = sign_q;
      mode_d     = mode_q;
      special_d  = special_q;
      spec_res_d = spec_res_q;
      spec_flg_d = spec_flg_q;
      out_d      = out_q;
      flg_d      = flg_q;
      vld_d      = 1'b0;
      case (state_q)
         IDLE: begin
            if (valid_data_in) begin
               sign_d     = sgn;
               mode_d     = rounding_mode;
               special_d  = special;
               spec_res_d = c_res;
               spec_flg_d = c_flg;
               rem_d      = rem_init;
               div_d      = b_sig;
               exp_d      = exp_init;
               quo_d      = '0;
               cnt_d      = '0;
               state_d    = special ? ROUND : DIVIDE;
            end
         end
         DIVIDE: begin
            // quo drops the leading quotient bit, which is always 1
            quo_d = {quo_q[23:0], rem_ge};
            rem_d = rem_ge ? {rem_sub[24:0], 1'b0}
                           : {rem_q[24:0], 1'b0};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == DIV_LAST) state_d = ROUND;
         end
         ROUND: begin
            state_d = IDLE;
            vld_d   = 1'b1;
            out_d   = special_q ? spec_res_q : n_res;
            flg_d   = special_q ? spec_flg_q : n_flg;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         rem_q      <= '0;
         quo_q      <= '0;
         div_q      <= '0;
         exp_q      <= '0;
         cnt_q      <= '0;
         sign_q     <= 1'b0;
         mode_q     <= RM_RNE;
         special_q  <= 1'b0;
         spec_res_q <= '0;
         spec_flg_q <= '0;
         out_q      <= '0;
         flg_q      <= '0;
         vld_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         rem_q      <= rem_d;
         quo_q      <= quo_d;
         div_q      <= div_d;
         exp_q      <= exp_d;
         cnt_q      <= cnt_d;
         sign_q     <= sign_d;
         mode_q     <= mode_d;
         special_q  <= special_d;
         spec_res_q <= spec_res_d;
         spec_flg_q <= spec_flg_d;
         out_q      <= out_d;
         flg_q      <= flg_d;
         vld_q      <= vld_d;
      end
   end

   assign ready_out         = state_q == IDLE;
   assign out               = out_q;
   assign overflow          = flg_q.overflow;
   assign underflow         = flg_q.underflow;
   assign inexact           = flg_q.inexact;
   assign invalid_operation = flg_q.invalid;
   assign divide_by_zero    = flg_q.div_zero;
   assign valid_data_out    = vld_q;

endmodule

// File: tb/tb_fp_divide_iterative.sv
// Self-checking bench for fp_divide_iterative.
// Directed table, handshake/reset sequences and a random model comparison.
module tb_fp_divide_iterative;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_data_in;
   logic        ready_out;
   logic [31:0] in1, in2;
   logic [2:0]  rounding_mode;
   logic [31:0] out;
   logic        overflow, underflow, inexact;
   logic        invalid_operation, divide_by_zero;
   logic        valid_data_out;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   fp_divide_iterative dut (
      .clk               (clk),
      .rst               (rst),
      .valid_data_in     (valid_data_in),
      .ready_out         (ready_out),
      .in1               (in1),
      .in2               (in2),
      .rounding_mode     (rounding_mode),
      .out               (out),
      .overflow          (overflow),
      .underflow         (underflow),
      .inexact           (inexact),
      .invalid_operation (invalid_operation),
      .divide_by_zero    (divide_by_zero),
      .valid_data_out    (valid_data_out)
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  m;
      logic [31:0] o;
      logic [4:0]  f;
      int          lat;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [4:0] flags();
      return {overflow, underflow, inexact,
              invalid_operation, divide_by_zero};
   endfunction

   task automatic check(input string name,
                        input logic [63:0] act,
                        input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Reference: exact rational quotient via integer division, then the
   // IEEE rounding rules; flags packed {ov, uf, nx, nv, dz}.
   function automatic logic [36:0] model(input logic [31:0] a,
                                         input logic [31:0] b,
                                         input logic [2:0]  m);
      logic [22:0] fa, fb;
      int ea, eb, e;
      bit za, zb, ia, ib, na, nb;
      logic s;
      logic [4:0] f;
      logic [31:0] r;
      longint unsigned ma, mb, num, q, rm, keep;
      bit g, rb, st, lost, up;
      fa = a[22:0];
      fb = b[22:0];
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      s  = a[31] ^ b[31];
      za = ea == 0;
      zb = eb == 0;
      ia = ea == 255 && fa == 0;
      ib = eb == 255 && fb == 0;
      na = ea == 255 && fa != 0;
      nb = eb == 255 && fb != 0;
      f  = 5'b0;
      f[3] = (za && fa != 0) || (zb && fb != 0);
      if (na && fa[22]) return {a, f};
      if (nb && fb[22]) return {b, f};
      f[1] = 1'b1;
      if (na) return {a | 32'h0040_0000, f};
      if (nb) return {b | 32'h0040_0000, f};
      if ((ia && ib) || (za && zb)) return {s, 31'h7FC0_0000, f};
      f[1] = 1'b0;
      if (ia) return {s, 31'h7F80_0000, f};
      if (ib) return {s, 31'h0, f};
      if (zb) begin
         f[0] = 1'b1;
         return {s, 31'h7F80_0000, f};
      end
      if (za) return {s, 31'h0, f};
      ma = 64'h80_0000 | 64'(fa);
      mb = 64'h80_0000 | 64'(fb);
      e  = ea - eb + 127;
      if (ma >= mb) num = ma << 25;
      else begin
         num = ma << 26;
         e   = e - 1;
      end
      q    = num / mb;
      rm   = num % mb;
      keep = q >> 2;
      g    = q[1];
      rb   = q[0];
      st   = rm != 0;
      lost = g | rb | st;
      case (m)
         3'd1:    up = 1'b0;
         3'd2:    up = s & lost;
         3'd3:    up = !s & lost;
         3'd4:    up = g;
         default: up = g & (rb | st | keep[0]);
      endcase
      keep = keep + 64'(up);
      if (keep == 64'h100_0000) begin
         keep = 64'h80_0000;
         e    = e + 1;
      end
      if (e > 254) begin
         f = 5'b10100;
         case (m)
            3'd1:    r = {s, 31'h7F7F_FFFF};
            3'd2:    r = s ? 32'hFF80_0000 : 32'h7F7F_FFFF;
            3'd3:    r = s ? 32'hFF7F_FFFF : 32'h7F80_0000;
            default: r = {s, 31'h7F80_0000};
         endcase
      end else if (e <= 0) begin
         f = 5'b01100;
         r = {s, 31'h0};
      end else begin
         f = {2'b00, lost, 2'b00};
         r = {s, e[7:0], keep[22:0]};
      end
      return {r, f};
   endfunction

   // Issues one operation; returns result, flags and accept-to-valid
   // latency. When now_ is set the operands are driven immediately.
   task automatic do_op(input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [2:0]  m,
                        input bit          now_,
                        output logic [31:0] o,
                        output logic [4:0]  f,
                        output int          lat,
                        output bit          busy_ok);
      int w;
      w = 0;
      if (!now_) begin
         @(negedge clk);
         while (!ready_out && w < 100) begin
            @(negedge clk);
            w++;
         end
      end
      in1           = a;
      in2           = b;
      rounding_mode = m;
      valid_data_in = 1'b1;
      @(posedge clk);
      #1 valid_data_in = 1'b0;
      lat     = 0;
      busy_ok = 1'b1;
      while (!valid_data_out && lat < 100) begin
         if (ready_out) busy_ok = 1'b0;
         @(posedge clk);
         #1;
         lat++;
      end
      o = out;
      f = flags();
   endtask

   logic [31:0] o;
   logic [4:0]  f;
   logic [36:0] ref_v;
   int          lat, pulses;
   bit          bok;
   logic [31:0] ra, rb_;
   logic [2:0]  rmode;
   logic [31:0] spec_pool[9];

   function automatic logic [31:0] rand_op(input int kind);
      logic [31:0] v;
      v = $urandom;
      if (kind < 60) v[30:23] = 8'($urandom_range(100, 154));
      else if (kind < 85) v[30:23] = 8'($urandom_range(1, 254));
      else v = spec_pool[$urandom_range(0, 8)];
      return v;
   endfunction

   initial begin
      spec_pool = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000,
                    32'hFF80_0000, 32'h7FC0_0000, 32'h7F80_0001,
                    32'h0000_0001, 32'h807F_FFFF, 32'h3F80_0000};

      vecs.push_back('{32'h40C0_0000, 32'h4000_0000, 3'd0,
                       32'h4040_0000, 5'b00000, 27});
      vecs.push_back('{32'h3F80_0000, 32'h4040_0000, 3'd0,
                       32'h3EAA_AAAB, 5'b00100, 27});
      vecs.push_back('{32'h3F80_0000, 32'h4040_0000, 3'd1,
                       32'h3EAA_AAAA, 5'b00100, 27});
      vecs.push_back('{32'h3F80_0000, 32'h0000_0000, 3'd0,
                       32'h7F80_0000, 5'b00001, 1});
      vecs.push_back('{32'h0000_0000, 32'h0000_0000, 3'd0,
                       32'h7FC0_0000, 5'b00010, 1});
      vecs.push_back('{32'h7F80_0001, 32'h3F80_0000, 3'd0,
                       32'h7FC0_0001, 5'b00010, 1});
      vecs.push_back('{32'h7F7F_FFFF, 32'h3F00_0000, 3'd0,
                       32'h7F80_0000, 5'b10100, 27});
      vecs.push_back('{32'h7F7F_FFFF, 32'h3F00_0000, 3'd1,
                       32'h7F7F_FFFF, 5'b10100, 27});
      vecs.push_back('{32'hFF7F_FFFF, 32'h3F00_0000, 3'd2,
                       32'hFF80_0000, 5'b10100, 27});
      vecs.push_back('{32'h0080_0000, 32'h4000_0000, 3'd0,
                       32'h0000_0000, 5'b01100, 27});
      vecs.push_back('{32'h0000_0001, 32'h3F80_0000, 3'd0,
                       32'h0000_0000, 5'b01000, 1});

      rst           = 1'b1;
      valid_data_in = 1'b0;
      in1           = '0;
      in2           = '0;
      rounding_mode = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_out", 64'(out), 64'h0);
      check("reset_flags", 64'(flags()), 64'h0);
      check("reset_valid", 64'(valid_data_out), 64'h0);
      check("reset_ready", 64'(ready_out), 64'h1);
      rst = 1'b0;

      foreach (vecs[i]) begin
         do_op(vecs[i].a, vecs[i].b, vecs[i].m, 1'b0, o, f, lat, bok);
         check($sformatf("vec%0d_out", i), 64'(o), 64'(vecs[i].o));
         check($sformatf("vec%0d_flags", i), 64'(f), 64'(vecs[i].f));
         check($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
         check($sformatf("vec%0d_busy", i), 64'(bok), 64'h1);
         check($sformatf("vec%0d_ready", i), 64'(ready_out), 64'h1);
         @(posedge clk);
         #1 check($sformatf("vec%0d_pulse", i),
                  64'(valid_data_out), 64'h0);
      end

      // Back-to-back: accept during the valid_data_out cycle.
      do_op(32'h40C0_0000, 32'h4000_0000, 3'd0, 1'b0, o, f, lat, bok);
      check("b2b_first", 64'(o), 64'h4040_0000);
      do_op(32'h3F80_0000, 32'h4040_0000, 3'd0, 1'b1, o, f, lat, bok);
      check("b2b_out", 64'(o), 64'h3EAA_AAAB);
      check("b2b_lat", 64'(lat), 64'd27);

      // A second valid during DIVIDE is dropped.
      @(negedge clk);
      in1           = 32'h40C0_0000;
      in2           = 32'h4000_0000;
      rounding_mode = 3'd0;
      valid_data_in = 1'b1;
      @(posedge clk);
      #1 valid_data_in = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      in1           = 32'h3F80_0000;
      in2           = 32'h4040_0000;
      valid_data_in = 1'b1;
      @(posedge clk);
      #1 valid_data_in = 1'b0;
      pulses = 0;
      o      = '0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         #1;
         if (valid_data_out) begin
            pulses++;
            o = out;
         end
      end
      check("drop_pulses", 64'(pulses), 64'd1);
      check("drop_out", 64'(o), 64'h4040_0000);

      // Reset in the middle of an iteration run.
      @(negedge clk);
      in1           = 32'h3F80_0000;
      in2           = 32'h4040_0000;
      valid_data_in = 1'b1;
      @(posedge clk);
      #1 valid_data_in = 1'b0;
      repeat (10) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("abort_out", 64'(out), 64'h0);
      check("abort_flags", 64'(flags()), 64'h0);
      check("abort_ready", 64'(ready_out), 64'h1);
      @(negedge clk);
      rst    = 1'b0;
      pulses = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         #1;
         if (valid_data_out) pulses++;
      end
      check("abort_pulses", 64'(pulses), 64'd0);

      // Random operands against the reference model.
      for (int n = 0; n < 250; n++) begin
         ra    = rand_op(int'($urandom_range(0, 99)));
         rb_   = rand_op(int'($urandom_range(0, 99)));
         rmode = 3'($urandom_range(0, 4));
         ref_v = model(ra, rb_, rmode);
         do_op(ra, rb_, rmode, 1'b0, o, f, lat, bok);
         check($sformatf("rnd%0d_%h_%h_m%0d", n, ra, rb_, rmode),
               {27'd0, o, f}, 64'(ref_v));
         check($sformatf("rnd%0d_lat", n), 64'(lat),
               (ra[30:23] == 8'h00 || ra[30:23] == 8'hFF ||
                rb_[30:23] == 8'h00 || rb_[30:23] == 8'hFF)
               ? 64'd1 : 64'd27);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
